window5x5_gen: RTL and testbench
================================

Name: window5x5_gen

Overview:
- Consumes the four row taps of the 4-row line buffer, plus the live pixel driving it, and assembles a 5x5 sliding window for the LeNet5 convolution engine.
- Tracks the row and column position within the frame.
- Flags each position where the window lies entirely inside the image ("valid" convolution, (ROWS-4)x(COLS-4) windows per frame).
- Sits directly downstream of the line buffer and upstream of the 5x5 MAC array.

Parameters:
- COLS, 32, pixels per image row; must equal the line buffer's COLS.
- ROWS, 32, image rows per frame.
- BIT_WIDTH, 8, pixel width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  pixel-accept strobe; the same signal drives the line buffer's en.
- px_in  input  BIT_WIDTH  current pixel; the same value as the line buffer's input.
- tap0  input  BIT_WIDTH  line buffer output, pixel 1 row earlier.
- tap1  input  BIT_WIDTH  pixel 2 rows earlier.
- tap2  input  BIT_WIDTH  pixel 3 rows earlier.
- tap3  input  BIT_WIDTH  pixel 4 rows earlier.
- win  output  25*BIT_WIDTH  flattened window; element (r,c) at bits [(r*5+c)*BIT_WIDTH +: BIT_WIDTH].
- win_valid  output  1  one-cycle pulse when win holds a fully in-image window.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (rst low, asynchronous): all 25 window registers 0, row/col counters 0, win_valid 0, frame_done 0.
- Row mapping: r0 <- tap3 (oldest row), r1 <- tap2, r2 <- tap1, r3 <- tap0, r4 <- px_in. Column c0 is the oldest column, c4 the newest.
- On a rising edge with en=1:
  - Each row shifts one place toward c0.
  - c4 of each row loads its source.
  - col increments.
  - When col = COLS-1, col wraps to 0 and row increments.
  - When row = ROWS-1 and col = COLS-1, both counters wrap to 0.
- win_valid:
  - Registered; set to 1 on the edge that accepts a pixel with row>=4 and col>=4 (coordinates before increment).
  - Otherwise cleared on every edge.
  - Latency: win and win_valid change on the same edge, one cycle after the pixel is presented.
- Output position: while win_valid is high, the window's output position is (row_accepted-4, col_accepted-4).
- frame_done: set to 1 on the edge accepting pixel (ROWS-1, COLS-1); otherwise cleared on every edge.
- en=0: window, counters and outputs hold, except that win_valid and frame_done clear to 0. Gaps of any length are allowed.
- Column wrap: at cols 0..3 the window mixes the previous row's tail with the new row's head; win_valid is suppressed there. No flush is needed.
- Frame wrap:
  - No clearing between frames.
  - Rows 0..3 of a new frame produce no valid windows.
  - From row 4 onward, the taps carry only new-frame data.
- Counter widths: $clog2(COLS) and $clog2(ROWS), compared against COLS-1 and ROWS-1 exactly. Non-power-of-two sizes must wrap correctly.
- Reset mid-frame:
  - Everything above returns to its reset value immediately; the next accepted pixel is (0,0).
  - The line buffer shares rst, so its contents restart consistently.
- Arithmetic: none on pixel data; pure registers, no saturation or sign handling.

Optional Feature:
- Macro: WIN5_COORD_EN.
- Defined: adds ports out_row (output, $clog2(ROWS)) and out_col (output, $clog2(COLS)).
  - Both are registered on the same edge as win_valid, with the output position (row-4, col-4).
  - Both hold their values when win_valid is 0; both reset to 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Load and first window:
  - Stimulus: reset, then stream one 32x32 frame with en=1 continuously. Pixel value = (row*32+col) mod 256, taps driven by a real line buffer instance.
  - Response: first win_valid one cycle after pixel (4,4) (value 132); win(0,0)=0, win(0,4)=4, win(4,0)=128, win(4,4)=132.
- Valid count and frame end:
  - Stimulus: the same full frame.
  - Response: exactly 784 win_valid pulses; no pulse for any col<4 or row<4 pixel; frame_done pulses once, one cycle after pixel (31,31).
- en gaps:
  - Stimulus: the same frame with en randomly low 50% of cycles.
  - Response: the window sequence is identical to the gap-free run; win_valid never high in a cycle following en=0.
- Back-to-back frames:
  - Stimulus: a second frame with value = (row*32+col+7) mod 256.
  - Response: no valid windows for rows 0..3; first window win(4,4)=139 and win(0,0)=7.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously at pixel (10,17), release, restart the frame.
  - Response: win all zero and win_valid/frame_done 0 while in reset; next frame output matches test 1 exactly.
- With WIN5_COORD_EN defined:
  - Stimulus: a full frame.
  - Response: out_row/out_col run from (0,0) to (27,27) in raster order with the valid pulses.

Source files
------------

// File: rtl/window5x5_gen.sv
// ============================================================================
// Module   : window5x5_gen
// Purpose  : Assembles a 5x5 sliding pixel window from four line-buffer taps
//            plus the live pixel, tracks frame position, and flags windows
//            that lie fully inside the image.
// Option   : define WIN5_COORD_EN to add the out_row/out_col position ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module window5x5_gen #(
    parameter int COLS      = 32,
    parameter int ROWS      = 32,
    parameter int BIT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [BIT_WIDTH-1:0]      px_in,
    input  logic [BIT_WIDTH-1:0]      tap0,
    input  logic [BIT_WIDTH-1:0]      tap1,
    input  logic [BIT_WIDTH-1:0]      tap2,
    input  logic [BIT_WIDTH-1:0]      tap3,
    output logic [25*BIT_WIDTH-1:0]   win,
`ifdef WIN5_COORD_EN
    output logic [$clog2(ROWS)-1:0]   out_row,
    output logic [$clog2(COLS)-1:0]   out_col,
`endif
    output logic                      win_valid,
    output logic                      frame_done
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    localparam logic [CW-1:0] c_col_last = CW'(COLS - 1);
    localparam logic [RW-1:0] c_row_last = RW'(ROWS - 1);
    localparam logic [CW-1:0] c_col_off  = CW'(4);
    localparam logic [RW-1:0] c_row_off  = RW'(4);

    logic [25*BIT_WIDTH-1:0] win_q, win_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;

    logic [BIT_WIDTH-1:0]    w_src [5];
    logic                    w_last_col;
    logic                    w_last_row;
    logic                    w_inside;

    // Row 0 is the oldest image row, row 4 the live pixel.
    assign w_src[0] = tap3;
    assign w_src[1] = tap2;
    assign w_src[2] = tap1;
    assign w_src[3] = tap0;
    assign w_src[4] = px_in;

    assign w_last_col = (col_q == c_col_last);
    assign w_last_row = (row_q == c_row_last);
    assign w_inside   = (col_q >= c_col_off) && (row_q >= c_row_off);

    always_comb begin
        win_d   = win_q;
        col_d   = col_q;
        row_d   = row_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (en) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_d[(r*5+c)*BIT_WIDTH +: BIT_WIDTH] =
                        win_q[(r*5+c+1)*BIT_WIDTH +: BIT_WIDTH];
                end
                win_d[(r*5+4)*BIT_WIDTH +: BIT_WIDTH] = w_src[r];
            end
            valid_d = w_inside;
            done_d  = w_last_col && w_last_row;
            if (w_last_col) begin
                col_d = '0;
                row_d = w_last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            win_q   <= win_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

`ifdef WIN5_COORD_EN
    logic [RW-1:0] out_row_q;
    logic [CW-1:0] out_col_q;

    // Position registers only move when a valid window is produced.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_row_q <= '0;
            out_col_q <= '0;
        end else if (en && w_inside) begin
            out_row_q <= row_q - c_row_off;
            out_col_q <= col_q - c_col_off;
        end
    end

    assign out_row = out_row_q;
    assign out_col = out_col_q;
`endif

    assign win        = win_q;
    assign win_valid  = valid_q;
    assign frame_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_window5x5_gen.sv
// ============================================================================
// Module   : tb_window5x5_gen
// Purpose  : Directed self-checking bench for window5x5_gen with a behavioural
//            4-row line buffer feeding the taps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_window5x5_gen;

    localparam int COLS = 32;
    localparam int ROWS = 32;
    localparam int BW   = 8;

    logic            clk;
    logic            rst;
    logic            en;
    logic [BW-1:0]   px_in;
    logic [BW-1:0]   tap0, tap1, tap2, tap3;
    logic [25*BW-1:0] win;
    logic            win_valid;
    logic            frame_done;
`ifdef WIN5_COORD_EN
    logic [4:0]      out_row;
    logic [4:0]      out_col;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt;
    logic [25*BW-1:0] prev_win;

    window5x5_gen #(.COLS(COLS), .ROWS(ROWS), .BIT_WIDTH(BW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .px_in      (px_in),
        .tap0       (tap0),
        .tap1       (tap1),
        .tap2       (tap2),
        .tap3       (tap3),
        .win        (win),
`ifdef WIN5_COORD_EN
        .out_row    (out_row),
        .out_col    (out_col),
`endif
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line buffer model: lb[k] is the pixel accepted k+1 strobes ago.
    logic [BW-1:0] lb [4*COLS];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4*COLS; k++) lb[k] <= '0;
        end else if (en) begin
            for (int k = 4*COLS-1; k > 0; k--) lb[k] <= lb[k-1];
            lb[0] <= px_in;
        end
    end
    assign tap0 = lb[COLS-1];
    assign tap1 = lb[2*COLS-1];
    assign tap2 = lb[3*COLS-1];
    assign tap3 = lb[4*COLS-1];

    task automatic check_eq(input string tag, input logic [255:0] obs,
                            input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] pix(input int r, input int c, input int off);
        return BW'((r*COLS + c + off) % 256);
    endfunction

    function automatic logic [25*BW-1:0] exp_win(input int r, input int c, input int off);
        logic [25*BW-1:0] w;
        w = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                w[(i*5+j)*BW +: BW] = pix(r-4+i, c-4+j, off);
        return w;
    endfunction

    task automatic idle_cycle();
        en = 1'b0;
        @(posedge clk); #1;
        check_eq("gap_valid", 256'(win_valid), 256'(0));
        check_eq("gap_done", 256'(frame_done), 256'(0));
        check_eq("gap_hold", 256'(win), 256'(prev_win));
    endtask

    task automatic send(input int r, input int c, input int off, input bit gaps);
        bit exp_v;
        int guard;
        guard = 0;
        while (gaps && ($urandom_range(0, 1) == 1) && guard < 16) begin
            idle_cycle();
            guard++;
        end
        en    = 1'b1;
        px_in = pix(r, c, off);
        @(posedge clk); #1;
        en    = 1'b0;
        exp_v = (r >= 4) && (c >= 4);
        check_eq("valid", 256'(win_valid), 256'(exp_v));
        check_eq("done", 256'(frame_done), 256'((r == ROWS-1) && (c == COLS-1)));
        if (exp_v) begin
            valid_cnt++;
            check_eq("win", 256'(win), 256'(exp_win(r, c, off)));
`ifdef WIN5_COORD_EN
            check_eq("out_row", 256'(out_row), 256'(r-4));
            check_eq("out_col", 256'(out_col), 256'(c-4));
`endif
        end
        if (r == 4 && c == 4) begin
            check_eq("w00", 256'(win[0*BW +: BW]),  256'(0 + off));
            check_eq("w04", 256'(win[4*BW +: BW]),  256'(4 + off));
            check_eq("w40", 256'(win[20*BW +: BW]), 256'(128 + off));
            check_eq("w44", 256'(win[24*BW +: BW]), 256'(132 + off));
        end
        prev_win = win;
    endtask

    // Streams a frame; stops just before pixel (sr,sc) when sr >= 0.
    task automatic run_frame(input int off, input bit gaps, input int sr, input int sc);
        valid_cnt = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r == sr && c == sc) return;
                send(r, c, off, gaps);
            end
        end
        check_eq("valid_count", 256'(valid_cnt), 256'(784));
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        px_in    = '0;
        prev_win = '0;
        #12;
        check_eq("rst_win", 256'(win), 256'(0));
        check_eq("rst_valid", 256'(win_valid), 256'(0));
        check_eq("rst_done", 256'(frame_done), 256'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        run_frame(0, 1'b0, -1, -1);
        run_frame(0, 1'b1, -1, -1);
        run_frame(7, 1'b0, -1, -1);

        run_frame(0, 1'b0, 10, 17);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_win", 256'(win), 256'(0));
        check_eq("mid_rst_valid", 256'(win_valid), 256'(0));
        check_eq("mid_rst_done", 256'(frame_done), 256'(0));
        en = 1'b1;
        px_in = 8'hAA;
        @(posedge clk); #1;
        check_eq("held_rst_win", 256'(win), 256'(0));
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        prev_win = '0;
        @(posedge clk); #1;
        run_frame(0, 1'b0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
